// File: rtl/fire_detect_mc.sv
// rtl/fire_detect_mc.sv - multi-channel EMA fire detector with persistence and hysteresis
module fire_detect_mc #(
    parameter int NCH           = 4,
    parameter int CHW           = 2,
    parameter int DW            = 16,
    parameter int ALPHA         = 20,
    parameter int ASHIFT        = 6,
    parameter int THRESH_OFFSET = 200,
    parameter int CLEAR_OFFSET  = 100,
    parameter int PERSIST       = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  lux_in,
    input  logic [CHW-1:0] ch_in,
    input  logic           data_valid,
    input  logic           clr_all,
    output logic [NCH-1:0] fire_detected,
    output logic           alarm_any,
    output logic           event_valid,
    output logic [CHW-1:0] event_ch,
    output logic           event_level,
    output logic           ch_err
);
    localparam int SW = DW + ASHIFT + 1;

    logic [DW-1:0]  ema_q [NCH];
    logic [3:0]     cnt_q [NCH];
    logic [NCH-1:0] init_q;
    logic [NCH-1:0] alarm_q;
    logic [NCH-1:0] alarm_d;
    logic           alarm_any_q;
    logic           event_valid_q;
    logic [CHW-1:0] event_ch_q;
    logic           event_level_q;
    logic           ch_err_q;

    logic           ch_ok;
    logic [DW-1:0]  ema_s;
    logic [3:0]     cnt_s;
    logic           init_s;
    logic           alarm_s;
    logic [SW-1:0]  weighted;
    logic [DW-1:0]  ema_new;
    logic [DW:0]    set_lvl;
    logic [DW:0]    clr_lvl;
    logic           over;
    logic           under;
    logic [DW-1:0]  ema_d;
    logic [3:0]     cnt_d;
    logic           init_d;
    logic           alarm_n;
    logic           ev_d;
    logic           accept;

    // Select the addressed channel's state; out-of-range indices match nothing.
    always_comb begin
        ch_ok   = 1'b0;
        ema_s   = '0;
        cnt_s   = '0;
        init_s  = 1'b0;
        alarm_s = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_in == CHW'(c)) begin
                ch_ok   = 1'b1;
                ema_s   = ema_q[c];
                cnt_s   = cnt_q[c];
                init_s  = init_q[c];
                alarm_s = alarm_q[c];
            end
        end
    end

    assign accept   = data_valid && ch_ok && !clr_all;
    assign weighted = SW'(ALPHA) * SW'(lux_in) + SW'(2 ** ASHIFT - ALPHA) * SW'(ema_s);
    assign ema_new  = DW'(weighted >> ASHIFT);
    assign set_lvl  = {1'b0, ema_s} + (DW+1)'(THRESH_OFFSET);
    assign clr_lvl  = {1'b0, ema_s} + (DW+1)'(CLEAR_OFFSET);
    assign over     = {1'b0, lux_in} > set_lvl;
    assign under    = {1'b0, lux_in} <= clr_lvl;

    always_comb begin
        ema_d   = ema_s;
        cnt_d   = cnt_s;
        init_d  = init_s;
        alarm_n = alarm_s;
        ev_d    = 1'b0;
        if (!init_s) begin
            ema_d  = lux_in;
            init_d = 1'b1;
            cnt_d  = '0;
        end else if (!alarm_s) begin
            if (over) begin
                // Baseline frozen while counting so the fire is not averaged in.
                cnt_d = (cnt_s >= 4'(PERSIST - 1)) ? 4'(PERSIST) : cnt_s + 4'd1;
                if (cnt_s + 4'd1 == 4'(PERSIST)) begin
                    alarm_n = 1'b1;
                    ev_d    = 1'b1;
                end
            end else begin
                cnt_d = '0;
                ema_d = ema_new;
            end
        end else if (under) begin
            alarm_n = 1'b0;
            cnt_d   = '0;
            ema_d   = ema_new;
            ev_d    = 1'b1;
        end
    end

    always_comb begin
        alarm_d = alarm_q;
        if (clr_all) begin
            alarm_d = '0;
        end else if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_in == CHW'(c)) alarm_d[c] = alarm_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                ema_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            init_q        <= '0;
            alarm_q       <= '0;
            alarm_any_q   <= 1'b0;
            event_valid_q <= 1'b0;
            event_ch_q    <= '0;
            event_level_q <= 1'b0;
            ch_err_q      <= 1'b0;
        end else begin
            alarm_q       <= alarm_d;
            alarm_any_q   <= |alarm_d;
            event_valid_q <= 1'b0;
            ch_err_q      <= data_valid && !ch_ok && !clr_all;
            if (clr_all) begin
                for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
                init_q <= '0;
            end else if (accept) begin
                for (int c = 0; c < NCH; c++) begin
                    if (ch_in == CHW'(c)) begin
                        ema_q[c]  <= ema_d;
                        cnt_q[c]  <= cnt_d;
                        init_q[c] <= init_d;
                    end
                end
                if (ev_d) begin
                    event_valid_q <= 1'b1;
                    event_ch_q    <= ch_in;
                    event_level_q <= alarm_n;
                end
            end
        end
    end

    assign fire_detected = alarm_q;
    assign alarm_any     = alarm_any_q;
    assign event_valid   = event_valid_q;
    assign event_ch      = event_ch_q;
    assign event_level   = event_level_q;
    assign ch_err        = ch_err_q;
endmodule

// File: tb/tb_fire_detect_mc.sv
// tb/tb_fire_detect_mc.sv - randomized and directed bench for fire_detect_mc against a reference model
module tb_fire_detect_mc;
    localparam int NCH = 4;
    localparam int CHW = 3;
    localparam int DW  = 16;
    localparam int ALPHA = 20;
    localparam int ASHIFT = 6;
    localparam int TOFF = 200;
    localparam int COFF = 100;
    localparam int PERSIST = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  lux_in = '0;
    logic [CHW-1:0] ch_in = '0;
    logic           data_valid = 1'b0;
    logic           clr_all = 1'b0;
    logic [NCH-1:0] fire_detected;
    logic           alarm_any;
    logic           event_valid;
    logic [CHW-1:0] event_ch;
    logic           event_level;
    logic           ch_err;

    fire_detect_mc #(
        .NCH(NCH), .CHW(CHW), .DW(DW), .ALPHA(ALPHA), .ASHIFT(ASHIFT),
        .THRESH_OFFSET(TOFF), .CLEAR_OFFSET(COFF), .PERSIST(PERSIST)
    ) dut (
        .clk(clk), .rst(rst), .lux_in(lux_in), .ch_in(ch_in),
        .data_valid(data_valid), .clr_all(clr_all),
        .fire_detected(fire_detected), .alarm_any(alarm_any),
        .event_valid(event_valid), .event_ch(event_ch),
        .event_level(event_level), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint m_ema [NCH];
    int     m_cnt [NCH];
    bit     m_init [NCH];
    bit     m_alarm [NCH];
    bit     m_ev, m_lvl, m_err;
    int     m_ch;
    int     n_events = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ema[c] = 0; m_cnt[c] = 0; m_init[c] = 0; m_alarm[c] = 0;
        end
        m_ev = 0; m_lvl = 0; m_err = 0; m_ch = 0;
    endtask

    task automatic model_step(input bit v, input int ch, input int lux, input bit clr);
        longint ema_new;
        m_ev = 0;
        m_err = 0;
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_init[c] = 0; m_alarm[c] = 0;
            end
        end else if (v && ch >= NCH) begin
            m_err = 1;
        end else if (v) begin
            ema_new = (ALPHA * lux + (2 ** ASHIFT - ALPHA) * m_ema[ch]) / (2 ** ASHIFT);
            if (!m_init[ch]) begin
                m_ema[ch] = lux; m_init[ch] = 1; m_cnt[ch] = 0;
            end else if (!m_alarm[ch]) begin
                if (lux > m_ema[ch] + TOFF) begin
                    if (m_cnt[ch] + 1 == PERSIST) begin
                        m_alarm[ch] = 1; m_ev = 1; m_lvl = 1; m_ch = ch;
                    end
                    m_cnt[ch] = (m_cnt[ch] + 1 > PERSIST) ? PERSIST : m_cnt[ch] + 1;
                end else begin
                    m_cnt[ch] = 0; m_ema[ch] = ema_new;
                end
            end else if (lux <= m_ema[ch] + COFF) begin
                m_alarm[ch] = 0; m_cnt[ch] = 0; m_ema[ch] = ema_new;
                m_ev = 1; m_lvl = 0; m_ch = ch;
            end
        end
        if (m_ev) n_events++;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] exp_fd;
        for (int c = 0; c < NCH; c++) exp_fd[c] = m_alarm[c];
        chk("fire_detected", 32'(fire_detected), 32'(exp_fd));
        chk("alarm_any", 32'(alarm_any), 32'(|exp_fd));
        chk("event_valid", 32'(event_valid), 32'(m_ev));
        chk("event_ch", 32'(event_ch), 32'(m_ch));
        chk("event_level", 32'(event_level), 32'(m_lvl));
        chk("ch_err", 32'(ch_err), 32'(m_err));
        for (int c = 0; c < NCH; c++) chk("ema", 32'(dut.ema_q[c]), 32'(m_ema[c]));
    endtask

    task automatic step(input bit v, input int ch, input int lux, input bit clr);
        data_valid = v;
        ch_in = CHW'(ch);
        lux_in = DW'(lux);
        clr_all = clr;
        @(posedge clk);
        model_step(v, ch, lux, clr);
        #1;
        compare_all();
        data_valid = 1'b0;
        clr_all = 1'b0;
    endtask

    task automatic samp(input int ch, input int lux);
        step(1'b1, ch, lux, 1'b0);
    endtask

    int base [NCH];

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step(1'b0, 0, 0, 1'b0);

        samp(0, 1000); samp(0, 1000);
        samp(0, 1201); samp(0, 1201); samp(0, 1201);
        chk("alarm_raised_ch0", 32'(fire_detected[0]), 32'd1);
        samp(0, 1150);
        samp(0, 1100);
        chk("ema_after_clear", 32'(dut.ema_q[0]), 32'd1031);

        step(1'b0, 0, 0, 1'b1);
        samp(0, 1000);
        samp(0, 1200); samp(0, 1200); samp(0, 1200);
        samp(0, 1201); samp(0, 900); samp(0, 1201); samp(0, 1201);

        samp(1, 500); samp(2, 60000);
        samp(1, 701); samp(2, 60100); samp(1, 701); samp(1, 701);
        samp(2, 65535); samp(2, 65535); samp(2, 65535);
        chk("ch2_no_wrap_alarm", 32'(fire_detected[2]), 32'd1);

        samp(5, 1234);
        samp(7, 0);
        step(1'b1, 3, 5000, 1'b1);
        step(1'b0, 0, 0, 1'b0);

        samp(3, 100); samp(3, 400); samp(3, 400); samp(3, 400);
        samp(0, 1000); samp(0, 1500); samp(0, 1500);
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        samp(0, 1500);
        chk("reinit_ema", 32'(dut.ema_q[0]), 32'd1500);

        step(1'b0, 0, 0, 1'b1);
        for (int c = 0; c < NCH; c++) base[c] = 300 + c * 15000;
        for (int i = 0; i < 600; i++) begin
            int ch, lux;
            bit v, clr;
            ch  = $urandom_range(0, 5);
            v   = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 79) == 0);
            lux = (ch < NCH) ? base[ch] + $urandom_range(0, 450) - 100 : $urandom_range(0, 65535);
            if (lux < 0) lux = 0;
            if (lux > 65535) lux = 65535;
            step(v, ch, lux, clr);
        end
        chk("random_events_seen", 32'(n_events > 4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fire_detect_mc.md
Name: fire_detect_mc

Overview:
Multi-channel, parametrised successor to the single-channel EMA fire detector. Per-channel light samples arrive time-multiplexed on one bus tagged with a channel index. Each channel keeps its own EMA baseline, a persistence counter, a hysteresis alarm latch and a baseline freeze, so a fire does not get absorbed into the baseline. The block sits between the lux sensor sampler/mux and the alarm/telemetry logic, and emits per-channel alarm levels plus a one-cycle change event.

Parameters:
NCH, 4, number of sensor channels (2..16)
CHW, 2, channel index width, must be at least clog2(NCH)
DW, 16, lux sample width
ALPHA, 20, EMA weight numerator on new sample, 1..2^ASHIFT-1
ASHIFT, 6, EMA denominator exponent (weight = ALPHA/2^ASHIFT)
THRESH_OFFSET, 200, set margin above baseline
CLEAR_OFFSET, 100, clear margin above baseline, must be at most THRESH_OFFSET
PERSIST, 3, consecutive over-threshold samples needed to raise alarm (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
lux_in  in  DW  sample value
ch_in  in  CHW  channel of sample
data_valid  in  1  sample strobe, one sample per cycle max
clr_all  in  1  synchronous re-arm: clears all alarms, counters and init flags
fire_detected  out  NCH  per-channel alarm level, registered
alarm_any  out  1  OR of fire_detected, registered
event_valid  out  1  one-cycle pulse when a channel's alarm changes
event_ch  out  CHW  channel of the event
event_level  out  1  new alarm level of the event
ch_err  out  1  one-cycle pulse: data_valid with ch_in >= NCH

Behaviour:
- Reset (async, rst=1): all outputs 0; every channel's ema=0, init=0, cnt=0, alarm=0.
- Per-channel state: ema[DW], init, cnt[4], alarm. There are no other state elements.
- Latency: the sample is accepted in cycle N when data_valid=1. State, fire_detected, alarm_any and the event outputs are valid at cycle N+1. Full throughput; there is no backpressure.
- Arithmetic:
  - ema_new = (ALPHA*lux + (2^ASHIFT-ALPHA)*ema) >> ASHIFT, computed at DW+ASHIFT+1 bits and truncated to DW.
  - set_lvl = ema + THRESH_OFFSET and clr_lvl = ema + CLEAR_OFFSET, both at DW+1 bits with no overflow wrap.
  - over = lux > set_lvl (strict). under = lux <= clr_lvl.
- Per accepted valid sample on channel c:
  - init=0: ema<=lux, init<=1, cnt<=0; no detection on this sample.
  - alarm=0 and over: cnt<=cnt+1, saturating at PERSIST; ema frozen. If cnt+1==PERSIST: alarm<=1 and an event fires.
  - alarm=0 and not over: cnt<=0, ema<=ema_new.
  - alarm=1 and under: alarm<=0, cnt<=0, ema<=ema_new, and an event fires with level 0.
  - alarm=1 and not under: no change; ema frozen.
- Invalid channel (ch_in >= NCH): no state change; ch_err pulses at N+1.
- Channels not addressed in a cycle hold their state.
- clr_all: takes priority over a simultaneous data_valid, which is dropped.
  - Clears every alarm, cnt and init; ema values are left as-is but are reloaded on the next sample.
  - Produces no events.
  - fire_detected and alarm_any read 0 at N+1.
- Event outputs: event_valid is 0 in every cycle without a change. event_ch and event_level hold their last values when event_valid=0.
- Events are produced by sample processing only; reset and clr_all never produce one.

Test Plan:
- Reset, then ch0 lux=1000 then 1000 -> ema0 stays 1000; fire_detected=0; event_valid never asserts.
- ch0 baseline 1000, then 1201,1201,1201 -> fire_detected[0]=1 one cycle after the 3rd sample; event_valid=1, event_ch=0, event_level=1 for exactly one cycle; ema0 stays 1000. Variant: 1200,1200,1200 -> no alarm (strict compare). Variant: 1201,900,1201,1201 -> no alarm (counter reset).
- ch0 alarmed, then 1150 -> alarm held, ema0 stays 1000. Then 1100 -> alarm clears; event with level 0; ema0=(20*1100+44*1000)>>6=1031.
- Interleave ch1 (baseline 500) and ch2 (baseline 60000, set_lvl=60200 with no wrap), with ch1 receiving 701 x3 -> only fire_detected[1]=1; alarm_any=1; ch2 with 65535 -> over, counts normally.
- NCH=4 with ch_in=5 while data_valid=1 -> ch_err pulse; no state change. clr_all together with data_valid -> sample dropped; all alarms 0; no event.
- Assert rst mid-count (after 2 of 3 over samples) -> outputs 0 immediately without a clock edge; next sample re-initialises the baseline.
